if_prefetch: RTL

Instruction prefetch unit that sits directly upstream of the core's IF/ID register. It fetches sequential 32-bit instructions from an instruction-memory bus with a request/grant/response handshake and queues them, with their PCs, in a small FIFO. It presents them to the fetch stage with valid/ready. A taken branch from EX flushes the queue and redirects fetching; responses to in-flight requests are discarded.

---
 rtl/if_prefetch_pkg.sv | 26 ++
 rtl/if_prefetch_inst_fifo.sv | 63 ++++++
 rtl/if_prefetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/if_prefetch_pkg.sv
// ============================================================
// Module   : if_prefetch_pkg
// Brief    : Shared widths, constants and entry type for the prefetcher.
// Revision : 1.0
// ============================================================
`default_nettype none

package if_prefetch_pkg;

  localparam int          c_INST_ADDR_W = 32;
  localparam int          c_INST_W      = 32;
  localparam logic [31:0] c_ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] c_PC_STEP     = 32'd4;

  typedef struct packed {
    logic [c_INST_ADDR_W-1:0] pc;
    logic [c_INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [c_INST_ADDR_W-1:0] align_pc(input logic [c_INST_ADDR_W-1:0] pc);
    return {pc[c_INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_prefetch_inst_fifo.sv
// ============================================================
// Module   : inst_fifo
// Brief    : Synchronous {pc, inst} FIFO with clear; head read from the array.
// Revision : 1.0
// ============================================================
`default_nettype none

module inst_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
// ============================================================
// Module   : if_prefetch
// Brief    : Sequential instruction prefetcher with credit-based issue and flush/redirect.
// Revision : 1.0
// ============================================================
`default_nettype none

module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [c_INST_ADDR_W-1:0] flush_pc_i,
  output logic                     bus_req_o,
  output logic [c_INST_ADDR_W-1:0] bus_addr_o,
  input  logic                     bus_gnt_i,
  input  logic                     bus_rvalid_i,
  input  logic [c_INST_W-1:0]      bus_rdata_i,
  output logic                     inst_valid_o,
  output logic [c_INST_W-1:0]      inst_o,
  output logic [c_INST_ADDR_W-1:0] inst_pc_o,
  input  logic                     inst_ready_i
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [c_INST_ADDR_W-1:0] r_fpc;
  logic [c_INST_ADDR_W-1:0] r_rpc;
  logic [c_INST_ADDR_W-1:0] r_req_addr;
  logic                     r_req_pend;
  logic                     r_req_stale;
  logic [OUT_W-1:0]         r_outst;
  logic [OUT_W-1:0]         r_discard;

  logic [CNT_W-1:0]         w_count;
  fetch_entry_t             w_head;
  fetch_entry_t             w_push_entry;
  logic [31:0]              w_inflight;
  logic                     w_credit;
  logic                     w_grant;
  logic                     w_drop;
  logic                     w_keep;
  logic                     w_pop;
  logic                     w_stale_grant;
  logic [OUT_W-1:0]         w_outst_nxt;
  logic [OUT_W-1:0]         w_discard_nxt;

  // Kept in-flight responses plus queued entries must fit in the FIFO.
  assign w_inflight    = 32'(w_count) + 32'(r_outst) - 32'(r_discard);
  assign w_credit      = (w_inflight < 32'(DEPTH)) && (32'(r_outst) < 32'(MAX_OUT));
  assign bus_req_o     = rst & (r_req_pend | w_credit);
  assign bus_addr_o    = r_req_pend ? r_req_addr : r_fpc;
  assign w_grant       = bus_req_o & bus_gnt_i;
  assign w_stale_grant = w_grant & r_req_pend & r_req_stale;
  assign w_drop        = bus_rvalid_i & (r_discard != '0);
  assign w_keep        = bus_rvalid_i & ~w_drop & ~flush_i;
  assign w_pop         = inst_valid_o & inst_ready_i & ~flush_i;

  always_comb begin
    w_outst_nxt   = r_outst;
    w_discard_nxt = r_discard;
    if (w_grant) w_outst_nxt = w_outst_nxt + OUT_W'(1);
    if (bus_rvalid_i && (r_outst != '0)) w_outst_nxt = w_outst_nxt - OUT_W'(1);
    // On redirect every request still owed a response becomes junk.
    if (flush_i) begin
      w_discard_nxt = w_outst_nxt;
    end else begin
      if (w_drop)        w_discard_nxt = w_discard_nxt - OUT_W'(1);
      if (w_stale_grant) w_discard_nxt = w_discard_nxt + OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc       <= RESET_PC;
      r_rpc       <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_req_pend  <= 1'b0;
      r_req_stale <= 1'b0;
      r_outst     <= '0;
      r_discard   <= '0;
    end else begin
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;

      // A raised request is held until granted; a flush only marks it stale.
      if (bus_req_o && !bus_gnt_i) begin
        r_req_pend  <= 1'b1;
        r_req_addr  <= bus_addr_o;
        r_req_stale <= flush_i | (r_req_pend & r_req_stale);
      end else if (w_grant) begin
        r_req_pend  <= 1'b0;
        r_req_stale <= 1'b0;
      end

      if (flush_i)                     r_fpc <= align_pc(flush_pc_i);
      else if (w_grant && !w_stale_grant) r_fpc <= r_fpc + c_PC_STEP;

      if (flush_i)     r_rpc <= align_pc(flush_pc_i);
      else if (w_keep) r_rpc <= r_rpc + c_PC_STEP;
    end
  end

  assign w_push_entry.pc   = r_rpc;
  assign w_push_entry.inst = bus_rdata_i;

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_keep),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .clear     (flush_i),
    .count     (w_count),
    .head      (w_head)
  );

  assign inst_valid_o = (w_count != '0);
  assign inst_o       = w_head.inst;
  assign inst_pc_o    = w_head.pc;

endmodule

`default_nettype wire
